// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them 8N1 at CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert one even-parity bit between data bit 7 and the stop bit.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_BITS     = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       tx,
  output logic       busy
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

  state_t              state_reg;
  logic [7:0]          shift_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic [2:0]          bit_idx_reg;
  logic                tx_reg;
  logic                busy_reg;
`ifdef UART_TX_PARITY_EN
  logic                parity_reg;
`endif

  logic bit_done;

  assign bit_done = (cnt_reg == CNT_LAST);

  // Pop only from IDLE; qualifying with rst keeps the strobe low while reset is held.
  assign rd_en = rst && (state_reg == IDLE) && !empty && tx_enable;

  assign tx   = tx_reg;
  assign busy = busy_reg;

  // tx_reg is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and stays glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (rd_en) begin
            state_reg <= FETCH;
            busy_reg  <= 1'b1;
          end
        end

        FETCH: begin
          shift_reg   <= rd_data;
`ifdef UART_TX_PARITY_EN
          parity_reg  <= ^rd_data;
`endif
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          tx_reg      <= 1'b0;
          state_reg   <= START;
        end

        START: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              // Next bit is shift_reg[1] because the shift lands on this same edge.
              tx_reg      <= shift_reg[1];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            tx_reg    <= 1'b1;
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at CLKS_PER_BIT=4: FIFO model, line decoder and byte scoreboard.
// Build with UART_TX_PARITY_EN defined to cover the parity frame format.
module tb_uart_tx_engine;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_enable;
  logic       empty;
  logic [7:0] rd_data = 8'h00;
  logic       rd_en;
  logic       tx;
  logic       busy;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on rd_data the cycle after rd_en.
  logic [7:0] fifo_mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= fifo_mem[rd_ptr % 16];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  logic [7:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  // Per-cycle observations, sampled 1 ns after the falling edge.
  int   cyc = 0;
  logic s_tx, s_busy, s_rd;
  logic prev_busy = 1'b0;
  int   rd_cnt = 0;
  int   busy_cnt = 0;
  int   last_rd_cyc = 0;
  logic rd_prev_busy = 1'b0;
  logic rd_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    #1;
    cyc++;
    s_tx   = tx;
    s_busy = busy;
    s_rd   = rd_en;
    if (s_rd) begin
      rd_cnt++;
      last_rd_cyc  = cyc;
      rd_prev_busy = prev_busy;
      rd_busy      = s_busy;
    end
    if (s_busy) busy_cnt++;
    prev_busy = s_busy;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr++;
    exp_q.push_back(b);
    $display("push 0x%02h (fifo depth %0d)", b, wr_ptr - rd_ptr);
  endtask

  task automatic push_fifo_only(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr++;
    $display("push 0x%02h (to be discarded by reset)", b);
  endtask

  // Waits for a start bit, then records every bit of the frame, checking each is held CPB cycles.
  task automatic capture_frame(input int drop_n, output logic [10:0] bits, output logic held,
                               output bit found, output int high_ticks, output int start_cyc);
    found = 1'b0;
    high_ticks = 0;
    start_cyc = 0;
    bits = '1;
    held = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (!s_tx) begin
        found = 1'b1;
        start_cyc = cyc;
      end else begin
        high_ticks++;
      end
    end
    if (found) begin
      bits[0] = 1'b0;
      for (int n = 1; n < NBITS * CPB; n++) begin
        if (n == drop_n) tx_enable = 1'b0;
        tick();
        if (n % CPB == 0) bits[n / CPB] = s_tx;
        else if (s_tx != bits[n / CPB]) held = 1'b0;
      end
    end
  endtask

  task automatic frame_check(input string tag, input int drop_n, input bit post_idle,
                             input int exp_rd, input int exp_gap, output logic [10:0] bits);
    logic held;
    bit   found;
    int   high_ticks, start_cyc;
    logic [7:0] exp_b;
    capture_frame(drop_n, bits, held, found, high_ticks, start_cyc);
    check({tag, "_start_seen"}, int'(found), 1);
    if (!found) return;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got byte 0x%02h, expected none queued", tag, bits[8:1]);
    end else begin
      exp_b = exp_q.pop_front();
      check({tag, "_byte"}, int'(bits[8:1]), int'(exp_b));
    end
    check({tag, "_stop_bit"}, int'(bits[NBITS-1]), 1);
    check({tag, "_bits_held"}, int'(held), 1);
    check({tag, "_rd_to_start"}, start_cyc - last_rd_cyc, 2);
    if (exp_gap >= 0) check({tag, "_idle_gap"}, high_ticks, exp_gap);
    if (post_idle) begin
      tick();
      check({tag, "_busy_low_after"}, int'(s_busy), 0);
      check({tag, "_rd_pulses"}, rd_cnt, exp_rd);
      check({tag, "_busy_cycles"}, busy_cnt, exp_rd * (1 + NBITS * CPB));
    end
    $display("frame %s: byte 0x%02h stop=%0b held=%0b gap=%0d", tag, bits[8:1], bits[NBITS-1], held, high_ticks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fb;
    int low_cnt;
    bit seen;

    vecs[0] = '{8'h07, 1'b1};
    vecs[1] = '{8'h03, 1'b0};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFE, 1'b1};

    // Reset held with data waiting: no pop, line idle.
    rst = 1'b0;
    tx_enable = 1'b1;
    push_byte(8'h55);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outputs", int'({s_tx, s_busy, s_rd}), 3'b100);
    end

    // Flow control: tx_enable low with data present blocks a new frame.
    tx_enable = 1'b0;
    rst = 1'b1;
    rd_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_tx) low_cnt++;
    end
    check("fc_hold_rd_pulses", rd_cnt, 0);
    check("fc_hold_tx_low_cycles", low_cnt, 0);

    // Single byte 0x55.
    tx_enable = 1'b1;
    rd_cnt = 0;
    busy_cnt = 0;
    frame_check("single_55", -1, 1'b1, 1, -1, fb);
`ifdef UART_TX_PARITY_EN
    check("single_55_parity", int'(fb[9]), 0);
`endif

    // Back-to-back frames.
    rd_cnt = 0;
    busy_cnt = 0;
    push_byte(8'hA5);
    push_byte(8'h3C);
    frame_check("b2b_first", -1, 1'b0, 0, -1, fb);
    frame_check("b2b_second", -1, 1'b1, 2, 2, fb);
    check("b2b_rd_one_after_busy_fall", int'({rd_prev_busy, rd_busy}), 2'b10);

    // Table of single frames covering data and parity patterns.
    for (int v = 0; v < 6; v++) begin
      rd_cnt = 0;
      busy_cnt = 0;
      push_byte(vecs[v].data);
      frame_check($sformatf("vec%0d", v), -1, 1'b1, 1, -1, fb);
`ifdef UART_TX_PARITY_EN
      check($sformatf("vec%0d_parity", v), int'(fb[9]), int'(vecs[v].exp_par));
`endif
    end

    // Dropping tx_enable mid-frame finishes the frame but starts no other.
    rd_cnt = 0;
    busy_cnt = 0;
    push_byte(8'h5A);
    push_byte(8'h69);
    frame_check("fc_drop", 18, 1'b1, 1, -1, fb);
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_tx) low_cnt++;
    end
    check("fc_drop_no_next_rd", rd_cnt, 1);
    check("fc_drop_tx_low_cycles", low_cnt, 0);
    tx_enable = 1'b1;
    rd_cnt = 0;
    busy_cnt = 0;
    frame_check("fc_resume", -1, 1'b1, 1, -1, fb);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line rising proves the reset).
    rd_cnt = 0;
    seen = 1'b0;
    push_fifo_only(8'hC3);
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (s_rd) seen = 1'b1;
    end
    check("rstmf_rd_seen", int'(seen), 1);
    repeat (18) tick();
    check("rstmf_data_bit3", int'(s_tx), 0);
    rst = 1'b0;
    tick();
    tick();
    check("rstmf_outputs", int'({s_tx, s_busy, s_rd}), 3'b100);
    rst = 1'b1;
    rd_cnt = 0;
    repeat (10) tick();
    check("rstmf_no_extra_pop", rd_cnt, 0);
    check("rstmf_fifo_empty", int'(empty), 1);
    busy_cnt = 0;
    push_byte(8'h96);
    frame_check("rstmf_restart", -1, 1'b1, 1, -1, fb);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
